// File: rtl/nn_pkg.sv
// Shared types and default sizing for the hidden-layer sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package nn_pkg;

    localparam int N_IN_DEF  = 784;  // inputs per neuron (accumulation length)
    localparam int N_HID_DEF = 200;  // hidden neurons per pass
    localparam int AW1_DEF   = 18;   // weight_1 SRAM address width
    localparam int AW3_DEF   = 10;   // input SRAM address width
    localparam int NW_DEF    = 8;    // neuron index width

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        TAIL,
        WAIT_MAC,
        WAIT_SIG,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/nn_layer_seq_if.sv
// Bundle of host, SRAM, MAC/sigmoid and status signals around the sequencer.
// Latency: none (wires only).
// Backpressure: mac_done / sig_ready stall the sequencer; no other flow control.
// Optional: NN_SEQ_CYCLE_CNT_EN adds the 32-bit cycle_count signal.
// Modports: slave = sequencer side, master = host/datapath side.
interface nn_layer_seq_if
    import nn_pkg::*;
#(
    parameter int AW1 = AW1_DEF,
    parameter int AW3 = AW3_DEF,
    parameter int NW  = NW_DEF
) ();

    logic           start;
    logic           host_we_1;
    logic           host_we_3;
    logic [AW1-1:0] host_addr_1;
    logic [AW3-1:0] host_addr_3;
    logic           we_1;
    logic           we_3;
    logic [AW1-1:0] address_1;
    logic [AW3-1:0] address_3;
    logic           mac_start;
    logic           mac_done;
    logic           sig_ready;
    logic           busy;
    logic           done;
    logic           result_valid;
    logic [NW-1:0]  neuron_idx;
    logic           err;
`ifdef NN_SEQ_CYCLE_CNT_EN
    logic [31:0]    cycle_count;
`endif

    modport slave (
        input  start, host_we_1, host_we_3, host_addr_1, host_addr_3,
        input  mac_done, sig_ready,
`ifdef NN_SEQ_CYCLE_CNT_EN
        output cycle_count,
`endif
        output we_1, we_3, address_1, address_3, mac_start,
        output busy, done, result_valid, neuron_idx, err
    );

    modport master (
        output start, host_we_1, host_we_3, host_addr_1, host_addr_3,
        output mac_done, sig_ready,
`ifdef NN_SEQ_CYCLE_CNT_EN
        input  cycle_count,
`endif
        input  we_1, we_3, address_1, address_3, mac_start,
        input  busy, done, result_valid, neuron_idx, err
    );

endinterface

// File: rtl/nn_addr_gen.sv
// Operand address generator: k (input SRAM) and wptr (weight SRAM) counters.
// Latency: counters advance on the edge after step_i; last_k_o is combinational.
// Backpressure: none; advances only when step_i is high.
// Ports: clk, reset (async active-low), clear_i, step_i, k_o, wptr_o, last_k_o.
module nn_addr_gen #(
    parameter int N_IN = 784,
    parameter int AW1  = 18,
    parameter int AW3  = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear_i,
    input  logic           step_i,
    output logic [AW3-1:0] k_o,
    output logic [AW1-1:0] wptr_o,
    output logic           last_k_o
);

    logic [AW3-1:0] k_q;
    logic [AW1-1:0] wptr_q;

    assign last_k_o = (k_q == AW3'(N_IN - 1));
    assign k_o      = k_q;
    assign wptr_o   = wptr_q;

    // k wraps to 0 after the last operand so the next neuron starts clean;
    // wptr runs on across neurons and therefore equals n*N_IN + k.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q    <= '0;
            wptr_q <= '0;
        end else if (clear_i) begin
            k_q    <= '0;
            wptr_q <= '0;
        end else if (step_i) begin
            k_q    <= last_k_o ? '0 : k_q + AW3'(1);
            wptr_q <= wptr_q + AW1'(1);
        end
    end

endmodule

// File: rtl/nn_layer_seq.sv
// Hidden-layer sequencer: streams N_IN operand addresses per neuron, waits for MAC and sigmoid, flags results.
// Latency: start -> first address next cycle; mac_start trails the address by one cycle (SRAM read).
// Backpressure: holds in WAIT_MAC / WAIT_SIG until mac_done / sig_ready; start ignored unless idle.
// Optional: NN_SEQ_CYCLE_CNT_EN adds the saturating 32-bit cycle_count output.
// Ports: clk, reset (async active-low), bus (nn_layer_seq_if.slave).
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_HID = N_HID_DEF,
    parameter int AW1   = AW1_DEF,
    parameter int AW3   = AW3_DEF,
    parameter int NW    = NW_DEF
) (
    input logic           clk,
    input logic           reset,
    nn_layer_seq_if.slave bus
);

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic            err_q, err_d;
    logic            mac_start_q, mac_start_d;
    logic            idle;
    logic            streaming;
    logic            start_acc;
    logic            last_k;
    logic [AW3-1:0]  k;
    logic [AW1-1:0]  wptr;

    assign idle      = (state_q == IDLE);
    assign streaming = (state_q == STREAM);
    assign start_acc = idle && bus.start;

    nn_addr_gen #(
        .N_IN (N_IN),
        .AW1  (AW1),
        .AW3  (AW3)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (start_acc),
        .step_i   (streaming),
        .k_o      (k),
        .wptr_o   (wptr),
        .last_k_o (last_k)
    );

    // Read data for an address presented this cycle reaches the MACs next cycle.
    assign mac_start_d = streaming;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        err_d   = err_q;

        // Protocol errors are flagged but never alter the schedule.
        if ((bus.mac_done && mac_start_q) ||
            (bus.sig_ready && (state_q inside {STREAM, TAIL, WAIT_MAC}))) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STREAM;
                    n_d     = '0;
                    err_d   = 1'b0;
                end
            end
            STREAM:   if (last_k) state_d = TAIL;
            TAIL:     state_d = WAIT_MAC;
            WAIT_MAC: if (bus.mac_done) state_d = WAIT_SIG;
            WAIT_SIG: if (bus.sig_ready) state_d = EMIT;
            EMIT: begin
                if (n_q == NW'(N_HID - 1)) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + NW'(1);
                    state_d = STREAM;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            err_q       <= 1'b0;
            mac_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            err_q       <= err_d;
            mac_start_q <= mac_start_d;
        end
    end

`ifdef NN_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    // Counts every cycle of the pass, the DONE cycle included; holds once idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else if (start_acc) begin
            cyc_q <= '0;
        end else if (!idle && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign bus.cycle_count = cyc_q;
`endif

    // Host owns the SRAM ports only while idle; writes are blocked during a pass.
    assign bus.we_1         = idle && bus.host_we_1;
    assign bus.we_3         = idle && bus.host_we_3;
    assign bus.address_1    = idle ? bus.host_addr_1 : wptr;
    assign bus.address_3    = idle ? bus.host_addr_3 : k;
    assign bus.mac_start    = mac_start_q;
    assign bus.busy         = state_q inside {STREAM, TAIL, WAIT_MAC, WAIT_SIG, EMIT};
    assign bus.done         = (state_q == DONE);
    assign bus.result_valid = (state_q == EMIT);
    assign bus.neuron_idx   = n_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq with N_IN=4, N_HID=3.
// Latency: per-neuron period of 10 cycles with the responder timing below.
// Backpressure: responder pulses mac_done 2 cycles after the last mac_start and sig_ready 2 cycles after that.
module tb_nn_layer_seq;

    localparam int N_IN  = 4;
    localparam int N_HID = 3;
    localparam int AW1   = 5;
    localparam int AW3   = 3;
    localparam int NW    = 2;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;
    int rv_cnt;
    int done_cnt;

    nn_layer_seq_if #(.AW1(AW1), .AW3(AW3), .NW(NW)) bus ();

    nn_layer_seq #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .AW1   (AW1),
        .AW3   (AW3),
        .NW    (NW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Runs one pass starting with a start pulse. Cycle i=1 is the first cycle after
    // the accepted start. Expected schedule: neuron n occupies cycles 10n+1..10n+10,
    // phase p 0..3 stream, mac_start on p 1..4, result_valid on p 9; DONE at 31.
    task automatic drive_pass(input bit chk, input int restart_at,
                              input int glitch_at, input int abort_at);
        int cnt;
        int n;
        int p;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        cnt      = -100;
        rv_cnt   = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            n = (i - 1) / 10;
            p = (i - 1) % 10;
            if (chk) begin
                exp_v = {(i <= 30), (i == 31), (i <= 30) && (p >= 1) && (p <= 4),
                         (i <= 30) && (p == 9)};
                got_v = {bus.busy, bus.done, bus.mac_start, bus.result_valid};
                tests_run++;
                if (got_v !== exp_v) begin
                    tests_failed++;
                    $display("FAIL sched_flags cyc=%0d busy/done/mac_start/rv got=%b exp=%b", i, got_v, exp_v);
                end
                if (i <= 30) begin
                    tests_run++;
                    if (bus.neuron_idx !== NW'(n)) begin
                        tests_failed++;
                        $display("FAIL neuron_idx cyc=%0d got=%0d exp=%0d", i, bus.neuron_idx, n);
                    end
                    tests_run++;
                    if ({bus.we_1, bus.we_3} !== 2'b00) begin
                        tests_failed++;
                        $display("FAIL we_blocked cyc=%0d got=%b exp=00", i, {bus.we_1, bus.we_3});
                    end
                    if (p <= 3) begin
                        tests_run++;
                        if (bus.address_3 !== AW3'(p)) begin
                            tests_failed++;
                            $display("FAIL address_3 cyc=%0d got=%0d exp=%0d", i, bus.address_3, p);
                        end
                        tests_run++;
                        if (bus.address_1 !== AW1'(n * N_IN + p)) begin
                            tests_failed++;
                            $display("FAIL address_1 cyc=%0d got=%0d exp=%0d", i, bus.address_1, n * N_IN + p);
                        end
                    end
                end
                if (i == 1) begin
                    tests_run++;
                    if (bus.err !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL err_clear_on_start got=%b exp=0", bus.err);
                    end
                end
            end
            if (bus.result_valid === 1'b1) rv_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (i == abort_at) begin
                bus.mac_done  = 1'b0;
                bus.sig_ready = 1'b0;
                return;
            end
            if (bus.mac_start === 1'b1) cnt = 0;
            else if (cnt >= 0) cnt++;
            bus.mac_done  = (cnt == 2) || (i == glitch_at);
            bus.sig_ready = (cnt == 4);
            bus.start     = (i == restart_at);
            @(negedge clk);
        end
        bus.mac_done  = 1'b0;
        bus.sig_ready = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.mac_start, bus.result_valid, bus.err, bus.we_1, bus.we_3} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=0000000",
                     {bus.busy, bus.done, bus.mac_start, bus.result_valid, bus.err, bus.we_1, bus.we_3});
        end
        tests_run++;
        if ({bus.neuron_idx, bus.address_1, bus.address_3} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values idx=%0d a1=%0d a3=%0d exp=0", bus.neuron_idx, bus.address_1, bus.address_3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_host_mux;
        bus.host_we_1   = 1'b1;
        bus.host_addr_1 = 5'd17;
        bus.host_we_3   = 1'b1;
        bus.host_addr_3 = 3'd5;
        #1;
        tests_run++;
        if ({bus.we_1, bus.we_3} !== 2'b11) begin
            tests_failed++;
            $display("FAIL host_we got=%b exp=11", {bus.we_1, bus.we_3});
        end
        tests_run++;
        if (bus.address_1 !== 5'd17 || bus.address_3 !== 3'd5) begin
            tests_failed++;
            $display("FAIL host_addr got a1=%0d a3=%0d exp a1=17 a3=5", bus.address_1, bus.address_3);
        end
    endtask

    task automatic test_nominal;
        drive_pass(1'b1, 0, 0, 0);
        tests_run++;
        if (rv_cnt != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL nominal_counts got rv=%0d done=%0d exp rv=3 done=1", rv_cnt, done_cnt);
        end
        tests_run++;
        if (bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_err got=%b exp=0", bus.err);
        end
        tests_run++;
        if (bus.we_3 !== 1'b1 || bus.address_3 !== 3'd5) begin
            tests_failed++;
            $display("FAIL host_mux_after_pass got we_3=%b a3=%0d exp we_3=1 a3=5", bus.we_3, bus.address_3);
        end
`ifdef NN_SEQ_CYCLE_CNT_EN
        tests_run++;
        if (bus.cycle_count !== 32'd31) begin
            tests_failed++;
            $display("FAIL cycle_count got=%0d exp=31", bus.cycle_count);
        end
`endif
        bus.host_we_1   = 1'b0;
        bus.host_addr_1 = '0;
        bus.host_we_3   = 1'b0;
        bus.host_addr_3 = '0;
    endtask

    task automatic test_restart_ignored;
        drive_pass(1'b1, 5, 0, 0);
        tests_run++;
        if (rv_cnt != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL restart_counts got rv=%0d done=%0d exp rv=3 done=1", rv_cnt, done_cnt);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_idle got busy=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_err;
        // Cycle 2 is stream phase 1 of neuron 0, where mac_start is high.
        drive_pass(1'b1, 0, 2, 0);
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky got=%b exp=1", bus.err);
        end
        tests_run++;
        if (rv_cnt != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL err_schedule got rv=%0d done=%0d exp rv=3 done=1", rv_cnt, done_cnt);
        end
        // The next pass checks err=0 in its first cycle.
        drive_pass(1'b1, 0, 0, 0);
        tests_run++;
        if (bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_after_clean_pass got=%b exp=0", bus.err);
        end
    endtask

    task automatic test_reset_midpass;
        // Cycle 18 is phase 7 of neuron 1: WAIT_SIG.
        drive_pass(1'b1, 0, 0, 18);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.mac_start, bus.result_valid, bus.err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL midreset_flags got=%b exp=00000",
                     {bus.busy, bus.done, bus.mac_start, bus.result_valid, bus.err});
        end
        tests_run++;
        if ({bus.neuron_idx, bus.address_1, bus.address_3} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_values idx=%0d a1=%0d a3=%0d exp=0", bus.neuron_idx, bus.address_1, bus.address_3);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            tests_run++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_no_done c=%0d got done=%b busy=%b exp 0 0", c, bus.done, bus.busy);
            end
        end
        drive_pass(1'b1, 0, 0, 0);
        tests_run++;
        if (rv_cnt != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL post_reset_pass got rv=%0d done=%0d exp rv=3 done=1", rv_cnt, done_cnt);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rv_cnt          = 0;
        done_cnt        = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.host_we_1   = 1'b0;
        bus.host_we_3   = 1'b0;
        bus.host_addr_1 = '0;
        bus.host_addr_3 = '0;
        bus.mac_done    = 1'b0;
        bus.sig_ready   = 1'b0;

        test_reset();
        test_host_mux();
        test_nominal();
        test_restart_ignored();
        test_err();
        test_reset_midpass();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
